// File: rtl/uart_telemetry_framer.sv
// Frames one telemetry FIFO word per packet for uart_tx:
// SYNC0 SYNC1 PKT_ID SEQ payload[MSB..LSB] CHK, where CHK = XOR(PKT_ID, SEQ, payload).
module uart_telemetry_framer #(
    parameter int         FIFO_RD_DATA_WIDTH = 64,
    parameter logic [7:0] SYNC0              = 8'hAA,
    parameter logic [7:0] SYNC1              = 8'h55,
    parameter logic [7:0] PKT_ID             = 8'h01
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fsm_en,
    input  logic [FIFO_RD_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                          fifo_empty,
    output logic                          fifo_rd_en,
    input  logic                          uart_tx_done,
    output logic                          uart_start_tx,
    output logic [7:0]                    uart_tx_din,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    localparam int N         = FIFO_RD_DATA_WIDTH / 8;
    localparam int FRAME_LEN = N + 5;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] IDX_SYNC0 = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SYNC1 = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ID    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_SEQ   = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_PAY0  = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_CHK   = IDX_W'(N + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_LOAD,
        S_WAIT
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [7:0]                    seq_q, seq_d;
    logic [15:0]                   pkt_q, pkt_d;
    logic [7:0]                    din_q, din_d;
    logic [FIFO_RD_DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [7:0]                    chk_q, chk_d;
    logic [7:0]                    cur_byte;

    // Byte selected by the frame index; payload always comes from the top of the shift register.
    always_comb begin
        cur_byte = shreg_q[FIFO_RD_DATA_WIDTH-1 -: 8];
        if (idx_q == IDX_SYNC0) begin
            cur_byte = SYNC0;
        end else if (idx_q == IDX_SYNC1) begin
            cur_byte = SYNC1;
        end else if (idx_q == IDX_ID) begin
            cur_byte = PKT_ID;
        end else if (idx_q == IDX_SEQ) begin
            cur_byte = seq_q;
        end else if (idx_q == IDX_CHK) begin
            cur_byte = chk_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        pkt_d   = pkt_q;
        din_d   = din_q;
        shreg_d = shreg_q;
        chk_d   = chk_q;

        case (state_q)
            S_IDLE: begin
                if (fsm_en && !fifo_empty) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shreg_d = fifo_rd_data;
                idx_d   = '0;
                chk_d   = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                din_d = cur_byte;
                if ((idx_q >= IDX_ID) && (idx_q != IDX_CHK)) begin
                    chk_d = chk_q ^ cur_byte;
                end
                if ((idx_q >= IDX_PAY0) && (idx_q != IDX_CHK)) begin
                    shreg_d = shreg_q << 8;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done pulses are only meaningful here; elsewhere they are ignored.
                if (uart_tx_done) begin
                    if (idx_q == IDX_CHK) begin
                        seq_d   = seq_q + 8'd1;
                        pkt_d   = pkt_q + 16'd1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            pkt_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            pkt_q   <= pkt_d;
            din_q   <= din_d;
        end
    end

    // Payload and checksum are always reloaded in LATCH before use, so they carry no reset.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        chk_q   <= chk_d;
    end

    assign fifo_rd_en    = (state_q == S_FETCH);
    assign uart_start_tx = (state_q == S_LOAD);
    assign uart_tx_din   = (state_q == S_LOAD) ? cur_byte : din_q;
    assign busy          = (state_q != S_IDLE);
    assign pkt_count     = pkt_q;

endmodule
